// File: rtl/jht_pkg.sv
// Shared types and defaults for the JHT write-side controller.
//   jht_upd_t         : one queued update {pc, dest}
//   jht_ctrl_state_e  : controller FSM state (INIT sweep / RUN)
//   JHT_SET_NUM       : default number of JHT sets (sweep length)
//   JHT_QDEPTH        : default update queue depth (power of two, >= 2)
package jht_pkg;

    localparam int JHT_SET_NUM = 8;
    localparam int JHT_QDEPTH  = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dest;
    } jht_upd_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } jht_ctrl_state_e;

endpackage

// File: rtl/jht_update_ctrl_if.sv
// Execute-stage to JHT-controller update interface.
//   upd_valid[1:0]  : per-lane resolved-jump update, lane 0 is older
//   upd_pc[1:0]     : jump instruction PC per lane
//   upd_dest[1:0]   : jump target per lane
//   upd_ready       : controller can take both lanes this cycle
//   inv_req         : one-cycle request to invalidate the whole JHT
//
// Handshake: a lane is transferred on a rising clock edge exactly when
// upd_valid[lane] && upd_ready are both high in that cycle (and inv_req is
// low). upd_ready covers both lanes at once and depends only on registered
// controller state, never on upd_valid. Lanes not transferred are dropped,
// so the producer must hold them until upd_ready is seen.
interface jht_update_ctrl_if;

    logic [1:0]       upd_valid;
    logic [1:0][31:0] upd_pc;
    logic [1:0][31:0] upd_dest;
    logic             upd_ready;
    logic             inv_req;

    modport master (
        output upd_valid, upd_pc, upd_dest, inv_req,
        input  upd_ready
    );

    modport slave (
        input  upd_valid, upd_pc, upd_dest, inv_req,
        output upd_ready
    );

endinterface

// File: rtl/jht_upd_queue.sv
// Dual-push / single-pop FIFO holding pending JHT updates.
//   clk, rst        : clock, asynchronous active-high reset
//   flush_i         : discard all entries, reset pointers (pushes dropped)
//   push_en_i       : push window open (caller guarantees >= 2 free slots)
//   push_valid_i    : per-lane valid, lane 0 enqueued first
//   push_data_i     : per-lane {pc, dest}
//   pop_o           : head is valid and is consumed this cycle
//   head_o          : head entry
//   count_o         : registered occupancy
// Optional feature (macro JHT_UPD_COALESCE_EN): a push whose PC matches a
// live queued entry (not the one popping this cycle) or lane 0 of the same
// cycle overwrites that entry's dest instead of taking a new slot.
module jht_upd_queue
    import jht_pkg::*;
#(
    parameter  int QDEPTH = JHT_QDEPTH,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_en_i,
    input  logic     [1:0]       push_valid_i,
    input  jht_upd_t [1:0]       push_data_i,
    output logic                 pop_o,
    output jht_upd_t             head_o,
    output logic     [CW-1:0]    count_o
);

    jht_upd_t          mem_q [QDEPTH];
    jht_upd_t          mem_d [QDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [PW-1:0]     wp;
    logic [CW-1:0]     nslot;

`ifdef JHT_UPD_COALESCE_EN
    logic [QDEPTH-1:0] live;
    logic [PW-1:0]     off;
    logic              hit0, hit1;
    logic [PW-1:0]     idx0, idx1;
`endif

    // The JHT write port always accepts, so a non-empty queue pops every cycle.
    assign pop_o   = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        mem_d = mem_q;
        wp    = wr_ptr_q;
        nslot = '0;
`ifdef JHT_UPD_COALESCE_EN
        hit0 = 1'b0;
        hit1 = 1'b0;
        idx0 = wr_ptr_q;
        idx1 = wr_ptr_q;
        off  = '0;
        // A slot is a coalesce target only if it holds a live entry that is
        // not leaving through the write port this cycle.
        for (int i = 0; i < QDEPTH; i++) begin
            off     = PW'(i) - rd_ptr_q;
            live[i] = (CW'(off) < count_q) && !(pop_o && (PW'(i) == rd_ptr_q));
        end
`endif

        if (push_en_i && push_valid_i[0]) begin
`ifdef JHT_UPD_COALESCE_EN
            for (int i = 0; i < QDEPTH; i++) begin
                if (live[i] && (mem_q[i].pc == push_data_i[0].pc)) begin
                    hit0 = 1'b1;
                    idx0 = PW'(i);
                end
            end
            if (hit0) begin
                mem_d[idx0].dest = push_data_i[0].dest;
            end else begin
                idx0      = wp;
                mem_d[wp] = push_data_i[0];
                wp        = wp + 1'b1;
                nslot     = nslot + 1'b1;
            end
`else
            mem_d[wp] = push_data_i[0];
            wp        = wp + 1'b1;
            nslot     = nslot + 1'b1;
`endif
        end

        if (push_en_i && push_valid_i[1]) begin
`ifdef JHT_UPD_COALESCE_EN
            // Same-cycle duplicate of lane 0 lands in whatever slot lane 0 used.
            if (push_valid_i[0] && (push_data_i[1].pc == push_data_i[0].pc)) begin
                hit1 = 1'b1;
                idx1 = idx0;
            end else begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (live[i] && (mem_q[i].pc == push_data_i[1].pc)) begin
                        hit1 = 1'b1;
                        idx1 = PW'(i);
                    end
                end
            end
            if (hit1) begin
                mem_d[idx1].dest = push_data_i[1].dest;
            end else begin
                mem_d[wp] = push_data_i[1];
                wp        = wp + 1'b1;
                nslot     = nslot + 1'b1;
            end
`else
            mem_d[wp] = push_data_i[1];
            wp        = wp + 1'b1;
            nslot     = nslot + 1'b1;
`endif
        end

        wr_ptr_d = wp;
        rd_ptr_d = rd_ptr_q + PW'(pop_o);
        count_d  = count_q + nslot - CW'(pop_o);

        // The head shown this cycle is still written; everything else is lost.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/jht_update_ctrl.sv
// JHT write-side controller: buffers resolved j/jal updates from two lanes
// and serialises them onto the JHT's single write port, and runs the
// invalidation sweep after reset or on software request.
//   clk, reset      : clock, asynchronous active-high reset
//   upd             : execute-side update interface (slave modport)
//   wr_en/pc/dest   : JHT is_write / executed_j_pc / dest_pc (zero when idle)
//   clr_en          : sweep clears metadata of set clr_index
//   clr_index       : set being cleared
//   init_done       : high while in RUN
//   q_count         : current update queue occupancy
//   dbg_state       : FSM state for observation
// Optional feature macro: JHT_UPD_COALESCE_EN (PC coalescing in the queue).
module jht_update_ctrl
    import jht_pkg::*;
#(
    parameter int SET_NUM = JHT_SET_NUM,
    parameter int QDEPTH  = JHT_QDEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    jht_update_ctrl_if.slave             upd,
    output logic                         wr_en,
    output logic [31:0]                  wr_pc,
    output logic [31:0]                  wr_dest,
    output logic                         clr_en,
    output logic [$clog2(SET_NUM)-1:0]   clr_index,
    output logic                         init_done,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count,
    output jht_ctrl_state_e              dbg_state
);

    localparam int SW = $clog2(SET_NUM);
    localparam int CW = $clog2(QDEPTH + 1);

    jht_ctrl_state_e state_q, state_d;
    logic [SW-1:0]   sweep_q, sweep_d;

    logic            flush;
    logic            push_en;
    logic            ready;
    logic            pop;
    jht_upd_t        head;
    jht_upd_t [1:0]  push_data;
    logic [CW-1:0]   count;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            push_data[l].pc   = upd.upd_pc[l];
            push_data[l].dest = upd.upd_dest[l];
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        clr_en  = 1'b0;
        flush   = 1'b0;
        push_en = 1'b0;
        ready   = 1'b0;
        case (state_q)
            INIT: begin
                clr_en = 1'b1;
                if (upd.inv_req) begin
                    sweep_d = '0;
                end else if (sweep_q == SW'(SET_NUM - 1)) begin
                    state_d = RUN;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            RUN: begin
                // Conservative: registered occupancy, this cycle's pop not credited.
                ready   = (count <= CW'(QDEPTH - 2));
                push_en = ready && !upd.inv_req;
                if (upd.inv_req) begin
                    flush   = 1'b1;
                    state_d = INIT;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    jht_upd_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (reset),
        .flush_i      (flush),
        .push_en_i    (push_en),
        .push_valid_i (upd.upd_valid),
        .push_data_i  (push_data),
        .pop_o        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    assign upd.upd_ready = ready;
    assign wr_en         = pop;
    assign wr_pc         = pop ? head.pc   : 32'd0;
    assign wr_dest       = pop ? head.dest : 32'd0;
    assign clr_index     = sweep_q;
    assign init_done     = (state_q == RUN);
    assign q_count       = count;
    assign dbg_state     = state_q;

endmodule
